// File: rtl/trace_packet_fifo.sv
// First-word-fall-through trace packet buffer feeding the trace-assisted cache.
// Raises a cache lock request once the fill level reaches LOCK_THRESHOLD and holds it until drained.
module trace_packet_fifo #(
    parameter int TRACE_WIDTH    = 128,
    parameter int DEPTH          = 8,
    parameter int LOCK_THRESHOLD = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           trace_wr_i,
    input  logic [TRACE_WIDTH-1:0]         trace_data_i,
    output logic                           trace_full_o,
    output logic [TRACE_WIDTH-1:0]         trace_out,
    output logic                           trace_capture_enable,
    input  logic                           trace_ack_i,
    output logic                           lock,
    output logic [$clog2(DEPTH+1)-1:0]     level_o,
    output logic                           overflow_o
);

    // state    | meaning
    // UNLOCKED | fill below threshold since last drain; cache free to evict
    // LOCKED   | threshold reached; held until the FIFO fully drains
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [TRACE_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [LVL_W-1:0]       level;
    logic [LVL_W-1:0]       level_nxt;
    lock_state_t            lock_state;
    logic                   push;
    logic                   pop;

    assign trace_full_o         = (level == LVL_W'(DEPTH));
    assign trace_capture_enable = (level != '0);
    assign push                 = trace_wr_i && !trace_full_o;
    assign pop                  = trace_capture_enable && trace_ack_i;
    assign level_o              = level;
    assign lock                 = (lock_state == LOCKED);
    // Storage is never cleared, so mask the head while empty.
    assign trace_out            = trace_capture_enable ? mem[rd_ptr] : '0;

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= trace_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            lock_state <= UNLOCKED;
        end else begin
            level <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // A write against a full FIFO is lost even if the head pops this cycle.
            if (trace_wr_i && trace_full_o) begin
                overflow_o <= 1'b1;
            end
            case (lock_state)
                UNLOCKED: if (level_nxt >= LVL_W'(LOCK_THRESHOLD)) lock_state <= LOCKED;
                LOCKED:   if (level_nxt == '0) lock_state <= UNLOCKED;
                default:  lock_state <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_packet_fifo.sv
// Directed bench for trace_packet_fifo with hand-computed expectations.
// Inputs change 1ns after the rising edge, outputs are checked at the same point.
module tb_trace_packet_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         trace_wr_i;
    logic [127:0] trace_data_i;
    logic         trace_full_o;
    logic [127:0] trace_out;
    logic         trace_capture_enable;
    logic         trace_ack_i;
    logic         lock;
    logic [3:0]   level_o;
    logic         overflow_o;

    int checks = 0;
    int errors = 0;

    trace_packet_fifo dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .trace_wr_i           (trace_wr_i),
        .trace_data_i         (trace_data_i),
        .trace_full_o         (trace_full_o),
        .trace_out            (trace_out),
        .trace_capture_enable (trace_capture_enable),
        .trace_ack_i          (trace_ack_i),
        .lock                 (lock),
        .level_o              (level_o),
        .overflow_o           (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pkt(input int i);
        logic [31:0] w;
        w = 32'h5A5A_0000 ^ 32'(i);
        return {4{w}};
    endfunction

    // One clock with the given inputs applied; inputs return idle afterwards.
    task automatic cyc(input logic wr, input logic [127:0] d, input logic ack, input logic fl);
        trace_wr_i   = wr;
        trace_data_i = d;
        trace_ack_i  = ack;
        flush_i      = fl;
        @(posedge clk);
        #1;
        trace_wr_i   = 1'b0;
        trace_data_i = '0;
        trace_ack_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cap"},   trace_capture_enable, 0);
        chk({tag, "_full"},  trace_full_o, 0);
        chk({tag, "_lock"},  lock, 0);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_ovf"},   overflow_o, 0);
        chk({tag, "_out"},   trace_out, 0);
    endtask

    initial begin
        logic [127:0] a5;
        a5           = {16{8'hA5}};
        rst          = 1'b1;
        flush_i      = 1'b0;
        trace_wr_i   = 1'b0;
        trace_data_i = '0;
        trace_ack_i  = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, pkt(1), 1'b0, 1'b0);
        rst = 1'b0;
        chk_idle("reset");

        // single packet, latency 1
        cyc(1'b1, a5, 1'b0, 1'b0);
        chk("a5_cap", trace_capture_enable, 1);
        chk("a5_out", trace_out, a5);
        chk("a5_level", level_o, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("a5_pop_level", level_o, 0);
        chk("a5_pop_cap", trace_capture_enable, 0);

        // ack while empty is ignored
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("ack_empty_level", level_o, 0);
        // push + ack while empty performs only the push
        cyc(1'b1, pkt(7), 1'b1, 1'b0);
        chk("pp_empty_level", level_o, 1);
        chk("pp_empty_out", trace_out, pkt(7));
        cyc(1'b0, '0, 1'b1, 1'b0);

        // fill to 8, overflow on 9th, drain in order
        for (int i = 1; i <= 8; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        chk("fill_full", trace_full_o, 1);
        chk("fill_level", level_o, 8);
        chk("fill_ovf0", overflow_o, 0);
        cyc(1'b1, pkt(9), 1'b0, 1'b0);
        chk("ovf_level", level_o, 8);
        chk("ovf_set", overflow_o, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_%0d", i), trace_out, pkt(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_level", level_o, 0);
        chk("drain_lock", lock, 0);
        chk("drain_ovf_sticky", overflow_o, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("flush_ovf", overflow_o, 0);

        // full with simultaneous push and ack: push dropped, head pops
        for (int i = 21; i <= 28; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        cyc(1'b1, pkt(99), 1'b1, 1'b0);
        chk("fullpp_level", level_o, 7);
        chk("fullpp_ovf", overflow_o, 1);
        chk("fullpp_full", trace_full_o, 0);
        for (int i = 22; i <= 28; i++) begin
            chk($sformatf("fullpp_drain_%0d", i), trace_out, pkt(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("fullpp_empty", trace_capture_enable, 0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // lock hysteresis
        for (int i = 1; i <= 5; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        chk("lock_at5", lock, 0);
        cyc(1'b1, pkt(6), 1'b0, 1'b0);
        chk("lock_at6", lock, 1);
        chk("lock_level6", level_o, 6);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lock_at3_level", level_o, 3);
        chk("lock_at3", lock, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lock_at1", lock, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lock_at0", lock, 0);
        chk("lock_level0", level_o, 0);

        // steady state at level 4 across pointer wrap
        for (int i = 40; i <= 43; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("wrap_head_%0d", k), trace_out, pkt(40 + k));
            cyc(1'b1, pkt(44 + k), 1'b1, 1'b0);
            chk($sformatf("wrap_level_%0d", k), level_o, 4);
        end
        chk("wrap_head_end", trace_out, pkt(60));
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk_idle("flush_a");

        // level 5, locked, overflowed, then flush with a write in the same cycle
        for (int i = 1; i <= 8; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        cyc(1'b1, pkt(9), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_flush_level", level_o, 5);
        chk("pre_flush_lock", lock, 1);
        chk("pre_flush_ovf", overflow_o, 1);
        chk("pre_flush_head", trace_out, pkt(4));
        cyc(1'b1, pkt(77), 1'b1, 1'b1);
        chk_idle("flush_b");

        // reset mid-operation overrides write and ack
        for (int i = 1; i <= 6; i++) cyc(1'b1, pkt(i), 1'b0, 1'b0);
        chk("pre_rst_lock", lock, 1);
        rst = 1'b1;
        cyc(1'b1, pkt(55), 1'b1, 1'b0);
        rst = 1'b0;
        chk_idle("rst_mid");
        cyc(1'b1, pkt(3), 1'b0, 1'b0);
        chk("post_rst_out", trace_out, pkt(3));
        chk("post_rst_level", level_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
